// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings fall through to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension of the returned memory word.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane = rdata >> {addr, 3'b000};
    data = lane;
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   data = {24'h0, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   data = {16'h0, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: req/ack data-memory handshake with pipeline stall.
// Optional REQ timeout abort when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o
);

  if (TIMEOUT >= (1 << CNT_W)) begin : g_cfg_err
    $error("CNT_W too narrow for TIMEOUT");
  end

  state_e          state;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            access_c;
  logic            misaligned_c;
  size_e           size_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_data;
`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;
`endif

  assign access_c = MemRead_i | MemWrite_i;
  assign stall_o  = ~rst_i & ((state == REQ) | ((state == IDLE) & access_c));

  // Byte enables, lane replication and alignment check for the incoming access.
  always_comb begin
    size_c       = f3_size(funct3_i);
    be_c         = '1;
    wdata_c      = wdata_i;
    misaligned_c = 1'b0;
    case (size_c)
      SZ_B: begin
        be_c    = BE_W'(1) << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_c         = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{wdata_i[15:0]}};
        misaligned_c = addr_i[0];
      end
      default: misaligned_c = |addr_i[1:0];
    endcase
  end

  load_align u_load_align (
    .rdata  (mem_rdata_i),
    .addr   (addr_lo_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          err_o <= 1'b0;
          if (access_c) begin
            // A simultaneous read and write is treated as a write.
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
            mem_be_o    <= be_c;
            mem_wdata_o <= wdata_c;
            funct3_q    <= funct3_i;
            addr_lo_q   <= addr_i[1:0];
            if (misaligned_c) begin
              state   <= DONE;
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else begin
              state     <= REQ;
              mem_req_o <= 1'b1;
`ifdef MEM_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            rdata_o   <= mem_we_o ? '0 : load_data;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            rdata_o   <= '0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          // Pipeline advances on this edge; never re-issue the same instruction.
          state <= IDLE;
          err_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int stall_seen = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0, exp_rdata = '0;
  logic [3:0]  exp_be = '0;

  typedef struct {
    bit rd; bit wr; bit [2:0] f3;
    bit [31:0] addr; bit [31:0] wdata; bit [31:0] rdata;
    int dly; int lit_stall; bit [31:0] lit_rdata; bit lit_err;
    bit [3:0] lit_be; bit [31:0] lit_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, lane mask, replication and extension.
  function automatic int size_b(input bit [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mis(input bit [2:0] f3, input bit [31:0] a);
    return (int'(a & 32'd3) % size_b(f3)) != 0;
  endfunction

  function automatic bit [3:0] m_be(input bit [2:0] f3, input bit [31:0] a);
    bit [3:0] be;
    int sz = size_b(f3);
    int base = int'(a & 32'd3);
    base = base - base % sz;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
    return be;
  endfunction

  function automatic bit [31:0] m_wd(input bit [2:0] f3, input bit [31:0] w);
    bit [31:0] r;
    int sz = size_b(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    int sz = size_b(f3);
    int off = int'(a & 32'd3);
    longint v;
    v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  // Compare process: DUT outputs against the expectations set by the driver.
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_o) stall_seen++;
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      chk("mem_req_o", 32'(mem_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("mem_addr_o", mem_addr_o, exp_addr);
        chk("mem_be_o", 32'(mem_be_o), 32'(exp_be));
        chk("mem_wdata_o", mem_wdata_o, exp_wd);
        chk("mem_we_o", 32'(mem_we_o), 32'(exp_we));
      end
      chk("err_o", 32'(err_o), 32'(exp_done & exp_err));
      if (exp_done) chk("rdata_o", rdata_o, exp_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit mis, to;
    int nreq;
    mis  = is_mis(v.f3, v.addr);
    to   = v.dly < 0;
    nreq = to ? TO : v.dly + 1;
    stall_seen = 0;
    MemRead_i = v.rd; MemWrite_i = v.wr; funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr = v.addr & ~32'h3; exp_be = m_be(v.f3, v.addr);
    exp_wd = m_wd(v.f3, v.wdata); exp_we = v.wr;
    @(negedge clk);
    step();
    if (!mis) begin
      for (int j = 0; j < nreq; j++) begin
        exp_req = 1'b1;
        mem_ack_i   = !to && (j == nreq - 1);
        mem_rdata_i = mem_ack_i ? v.rdata : 32'h5A5A5A5A;
        @(negedge clk);
        if (j == 0) begin
          chk("lit_be", 32'(mem_be_o), 32'(v.lit_be));
          chk("lit_wdata", mem_wdata_o, v.lit_wd);
        end
        step();
        mem_ack_i = 1'b0;
      end
    end
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1;
    exp_err   = mis || to;
    exp_rdata = (mis || to || v.wr) ? 32'h0 : m_load(v.f3, v.addr, v.rdata);
    @(negedge clk);
    chk("lit_rdata", rdata_o, v.lit_rdata);
    chk("lit_err", 32'(err_o), 32'(v.lit_err));
    step();
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    chk("stall_cycles", 32'(stall_seen), 32'(v.lit_stall));
    step();
  endtask

  initial begin
    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'd2;
    addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    step();
    step();
    @(negedge clk);
    chk("rst_stall_gated", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    step();
    rst_i = 1'b0; MemRead_i = 1'b0;
    chk_en = 1'b1;

    //                rd wr f3    addr          wdata         rdata         dly stl lit_rdata     err be     lit_wd
    vecs.push_back('{1, 0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,  2,  32'hDEADBEEF, 0, 4'hF, 32'h0});
    vecs.push_back('{1, 0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FFFFFF, 0,  2,  32'hFFFFFF80, 0, 4'h8, 32'h0});
    vecs.push_back('{1, 0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FFFFFF, 0,  2,  32'h00000080, 0, 4'h8, 32'h0});
    vecs.push_back('{0, 1, 3'd1, 32'h0000_0202, 32'h1234ABCD, 32'h0,        0,  2,  32'h0,        0, 4'hC, 32'hABCDABCD});
    vecs.push_back('{1, 0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        0,  1,  32'h0,        1, 4'h0, 32'h0});
    vecs.push_back('{1, 0, 3'd2, 32'h0000_0104, 32'h0,        32'h13579BDF, 5,  7,  32'h13579BDF, 0, 4'hF, 32'h0});
    vecs.push_back('{1, 0, 3'd1, 32'h0000_0106, 32'h0,        32'h80017FFF, 1,  3,  32'hFFFF8001, 0, 4'hC, 32'h0});
    vecs.push_back('{1, 0, 3'd5, 32'h0000_0106, 32'h0,        32'h80017FFF, 0,  2,  32'h00008001, 0, 4'hC, 32'h0});
    vecs.push_back('{0, 1, 3'd0, 32'h0000_0301, 32'h000000A5, 32'h0,        2,  4,  32'h0,        0, 4'h2, 32'hA5A5A5A5});
    vecs.push_back('{0, 1, 3'd2, 32'h0000_0400, 32'hCAFEF00D, 32'h0,        0,  2,  32'h0,        0, 4'hF, 32'hCAFEF00D});
    vecs.push_back('{1, 0, 3'd3, 32'h0000_010C, 32'h0,        32'h01234567, 0,  2,  32'h01234567, 0, 4'hF, 32'h0});
    vecs.push_back('{0, 1, 3'd1, 32'h0000_0203, 32'h0000FFFF, 32'h0,        0,  1,  32'h0,        1, 4'h0, 32'h0});
    vecs.push_back('{1, 1, 3'd2, 32'h0000_0500, 32'h11223344, 32'h99999999, 1,  3,  32'h0,        0, 4'hF, 32'h11223344});
    vecs.push_back('{1, 0, 3'd0, 32'h0000_0101, 32'h0,        32'h00007F00, 0,  2,  32'h0000007F, 0, 4'h2, 32'h0});
`ifdef MEM_TIMEOUT_EN
    vecs.push_back('{1, 0, 3'd2, 32'h0000_0700, 32'h0,        32'h0,        -1, TO + 1, 32'h0,    1, 4'hF, 32'h0});
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second REQ cycle, then a stray late ack.
    MemRead_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h600; wdata_i = 32'h0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr = 32'h600; exp_be = 4'hF; exp_wd = 32'h0; exp_we = 1'b0;
    @(negedge clk);
    step();
    exp_req = 1'b1;
    @(negedge clk);
    step();
    rst_i = 1'b1; exp_stall = 1'b0;
    @(negedge clk);
    step();
    rst_i = 1'b0; MemRead_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    exp_req = 1'b0; exp_stall = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", mem_addr_o, 32'h0);
    chk("post_rst_rdata", rdata_o, 32'h0);
    step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdata", rdata_o, 32'h0);
    chk("stray_ack_be", 32'(mem_be_o), 32'h0);
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
